// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous square wave in clk_input cycles, with loss-of-signal detection.
// Define HIGH_TIME_EN to also report the high time of each measured period on high_out.
module clk_period_meter #(
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned TIMEOUT = 120_000_000
) (
  input  logic             clk_input,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             locked,
  output logic             timeout
`ifdef HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_out
`endif
);

  // Last counter value before loss of signal; TIMEOUT must stay below 2^CNT_W.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync2_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             rise;
`ifdef HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
`endif

  assign rise = sync2_q & ~sync2_dly_q;

  // State, synchronizer and output registers.
  always_ff @(posedge clk_input) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      vld_q       <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef HIGH_TIME_EN
      hcnt_q      <= '0;
      high_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sig_in;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
`ifdef HIGH_TIME_EN
      hcnt_q      <= hcnt_d;
      high_q      <= high_d;
`endif
    end
  end

  // Next-state and output logic; a rise always wins over the timeout check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
`ifdef HIGH_TIME_EN
    hcnt_d    = hcnt_q;
    high_d    = high_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef HIGH_TIME_EN
        hcnt_d = '0;
`endif
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d  = cnt_q + CNT_W'(1);
          vld_d     = 1'b1;
          locked_d  = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
`ifdef HIGH_TIME_EN
          high_d    = hcnt_q + CNT_W'(sync2_q);
          hcnt_d    = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = '0;
`ifdef HIGH_TIME_EN
          hcnt_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef HIGH_TIME_EN
          hcnt_d = hcnt_q + CNT_W'(sync2_q);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period_out = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
`ifdef HIGH_TIME_EN
  assign high_out   = high_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: randomized and directed waveforms against a rise-spacing model.
module tb_clk_period_meter;

  localparam int unsigned CNT_W = 27;
  localparam int          TMO   = 100;
  localparam int          VW    = 2 * CNT_W + 3;
  localparam int          HIST  = 16384;

  logic             clk_input = 1'b0;
  logic             reset     = 1'b1;
  logic             sig_in    = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_vld;
  logic             locked;
  logic             timeout;
`ifdef HIGH_TIME_EN
  logic [CNT_W-1:0] high_out;
`endif

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk_input  (clk_input),
    .reset      (reset),
    .sig_in     (sig_in),
    .period_out (period_out),
    .period_vld (period_vld),
    .locked     (locked),
    .timeout    (timeout)
`ifdef HIGH_TIME_EN
    ,
    .high_out   (high_out)
`endif
  );

  always #5 clk_input = ~clk_input;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: works on the sampled input history and spacing between rising edges.
  bit s_hist [HIST];
  int cyc      = -1;
  int rst_edge = 0;
  int last_k   = 0;
  bit m_armed  = 1'b0;
  bit m_vld    = 1'b0;
  bit m_locked = 1'b0;
  bit m_tmo    = 1'b0;
  int m_period = 0;
  int m_high   = 0;

  always @(posedge clk_input) begin
    int k;
    cyc = cyc + 1;
    m_vld = 1'b0;
    if (cyc >= HIST) begin
      $display("FAIL history_overflow cyc=%0d actual=%0d required<%0d", cyc, cyc, HIST);
      $fatal(1);
    end
    if (reset) begin
      s_hist[cyc] = 1'b0;
      rst_edge = cyc;
      m_armed = 1'b0; m_locked = 1'b0; m_tmo = 1'b0; m_period = 0; m_high = 0;
    end else begin
      s_hist[cyc] = sig_in;
      k = cyc - 2;
      if (k > rst_edge) begin
        if (s_hist[k] && !s_hist[k-1]) begin
          if (m_armed) begin
            m_period = k - last_k;
            m_high = 0;
            for (int j = last_k + 1; j <= k; j++) m_high += int'(s_hist[j]);
            m_vld = 1'b1; m_locked = 1'b1; m_tmo = 1'b0;
          end
          m_armed = 1'b1;
          last_k = k;
        end else if (m_armed && (k - last_k) == TMO) begin
          m_tmo = 1'b1; m_locked = 1'b0; m_armed = 1'b0;
        end
      end
    end
  end

  function automatic logic [VW-1:0] obs();
`ifdef HIGH_TIME_EN
    return {period_vld, locked, timeout, period_out, high_out};
`else
    return {period_vld, locked, timeout, period_out, {CNT_W{1'b0}}};
`endif
  endfunction

  function automatic logic [VW-1:0] expv();
`ifdef HIGH_TIME_EN
    return {m_vld, m_locked, m_tmo, CNT_W'(m_period), CNT_W'(m_high)};
`else
    return {m_vld, m_locked, m_tmo, CNT_W'(m_period), {CNT_W{1'b0}}};
`endif
  endfunction

  bit wave [$];
  int reps [$];

  task automatic push_wave(input int hi, input int lo);
    for (int i = 0; i < hi; i++) wave.push_back(1'b1);
    for (int i = 0; i < lo; i++) wave.push_back(1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      @(negedge clk_input);
      n_checks++;
      if ({period_vld, locked, timeout, period_out} !== '0)
        $display("FAIL reset_hold cyc=%0d actual=%h required=0", cyc, {period_vld, locked, timeout, period_out});
      else n_pass++;
    end
    reset = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_input);
      n_checks++;
      if (period_vld !== 1'b0 || obs() !== expv())
        $display("FAIL reset_release cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_steady();
    int n_vld = 0;
    int first_vld = -1;
    wave.delete();
    for (int p = 0; p < 6; p++) push_wave(10, 10);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL steady_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (period_vld === 1'b1) begin
        n_vld++;
        if (first_vld < 0) first_vld = i;
        n_checks++;
`ifdef HIGH_TIME_EN
        if (period_out !== CNT_W'(20) || locked !== 1'b1 || high_out !== CNT_W'(10))
          $display("FAIL steady_value cyc=%0d actual=%0d/%0d/%0d required=20/1/10", cyc, period_out, locked, high_out);
`else
        if (period_out !== CNT_W'(20) || locked !== 1'b1)
          $display("FAIL steady_value cyc=%0d actual=%0d/%0d required=20/1", cyc, period_out, locked);
`endif
        else n_pass++;
      end
    end
    n_checks++;
    if (n_vld != 5 || first_vld != 22)
      $display("FAIL steady_pulses actual=%0d@%0d required=5@22", n_vld, first_vld);
    else n_pass++;
  endtask

  task automatic test_period_change();
    int exp_r [7] = '{20, 37, 37, 37, 8, 8, 8};
    int lock_bad = 0;
    wave.delete();
    reps.delete();
    for (int p = 0; p < 3; p++) push_wave(15, 22);
    for (int p = 0; p < 4; p++) push_wave(3, 5);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL change_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (period_vld === 1'b1) reps.push_back(int'(period_out));
      if (locked !== 1'b1) lock_bad++;
    end
    n_checks++;
    if (lock_bad != 0) $display("FAIL change_locked actual=%0d_low_cycles required=0", lock_bad);
    else n_pass++;
    n_checks++;
    if (reps.size() != 7) $display("FAIL change_count actual=%0d required=7", reps.size());
    else begin
      bit ok = 1'b1;
      foreach (exp_r[j]) if (reps[j] != exp_r[j]) ok = 1'b0;
      if (!ok) $display("FAIL change_values actual=%p required=%p", reps, exp_r);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int first_tmo = -1;
    int first_vld = -1;
    wave.delete();
    push_wave(5, 130);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL timeout_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (timeout === 1'b1 && first_tmo < 0) begin
        first_tmo = i;
        n_checks++;
        if (locked !== 1'b0 || period_out !== CNT_W'(8))
          $display("FAIL timeout_state cyc=%0d actual=%0d/%0d required=0/8", cyc, locked, period_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (first_tmo != 102) $display("FAIL timeout_latency actual=%0d required=102", first_tmo);
    else n_pass++;
    wave.delete();
    for (int p = 0; p < 3; p++) push_wave(10, 10);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL restart_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (i == 21) begin
        n_checks++;
        if (timeout !== 1'b1 || period_vld !== 1'b0)
          $display("FAIL restart_armed cyc=%0d actual=%0d/%0d required=1/0", cyc, timeout, period_vld);
        else n_pass++;
      end
      if (period_vld === 1'b1 && first_vld < 0) begin
        first_vld = i;
        n_checks++;
        if (timeout !== 1'b0 || period_out !== CNT_W'(20) || locked !== 1'b1)
          $display("FAIL restart_report cyc=%0d actual=%0d/%0d/%0d required=0/20/1", cyc, timeout, period_out, locked);
        else n_pass++;
      end
    end
    n_checks++;
    if (first_vld != 22) $display("FAIL restart_latency actual=%0d required=22", first_vld);
    else n_pass++;
  endtask

  task automatic test_boundary();
    bit saw_tmo = 1'b0;
    wave.delete();
    reps.delete();
    push_wave(50, 50);
    push_wave(50, 51);
    push_wave(10, 10);
    push_wave(10, 10);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL boundary_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (timeout === 1'b1) saw_tmo = 1'b1;
      if (period_vld === 1'b1) begin
        reps.push_back(int'(period_out));
        if (period_out === CNT_W'(TMO)) begin
          n_checks++;
          if (timeout !== 1'b0) $display("FAIL boundary_full actual=timeout%0d required=timeout0", timeout);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (!saw_tmo || reps.size() != 3 || reps[0] != 20 || reps[1] != 100 || reps[2] != 20)
      $display("FAIL boundary_reports actual=%p/tmo%0d required='{20,100,20}/tmo1", reps, saw_tmo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wave.delete();
    push_wave(10, 40);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL midrst_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
    end
    reset = 1'b1;
    sig_in = 1'b0;
    @(negedge clk_input);
    n_checks++;
    if (obs() !== '0) $display("FAIL midrst_clear cyc=%0d actual=%h required=0", cyc, obs());
    else n_pass++;
    reset = 1'b0;
    wave.delete();
    reps.delete();
    for (int p = 0; p < 3; p++) push_wave(10, 13);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL midrst_resume cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
      if (period_vld === 1'b1) reps.push_back(int'(period_out));
    end
    n_checks++;
    if (reps.size() != 2 || reps[0] != 23 || reps[1] != 23)
      $display("FAIL midrst_reports actual=%p required='{23,23}", reps);
    else n_pass++;
  endtask

  task automatic test_random();
    wave.delete();
    for (int p = 0; p < 40; p++) push_wave(int'($urandom_range(1, 55)), int'($urandom_range(1, 55)));
    push_wave(0, 5);
    foreach (wave[i]) begin
      sig_in = wave[i];
      @(negedge clk_input);
      n_checks++;
      if (obs() !== expv()) $display("FAIL random_model cyc=%0d actual=%h required=%h", cyc, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_steady();
    test_period_change();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Receive-side companion to the team's clock dividers. Takes a slow, free-running square wave (e.g. the 1 Hz divided clock, or any external slow signal) and measures its period in clk_input cycles. Reports each completed period and flags loss of signal. Used for self-check of divider outputs and for on-board frequency readout.

Parameters:
CNT_W, 27, width of period counter and period_out
TIMEOUT, 120_000_000, max cycles between rising edges before loss-of-signal is declared; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk_input  in   1      system clock (100 MHz)
reset      in   1      synchronous, active-high reset
sig_in     in   1      slow signal to measure; asynchronous to clk_input
period_out out  CNT_W  last measured period, in clk_input cycles
period_vld out  1      one-cycle pulse when period_out updates
locked     out  1      high after first full period measured; cleared on timeout
timeout    out  1      sticky loss-of-signal flag; cleared by next period_vld or reset

Behaviour:
- One clock. Reset is synchronous and active-high: clk_input / reset, sampled on the rising edge of clk_input.
- Reset values: period_out=0, period_vld=0, locked=0, timeout=0; sync flops=0; counter=0; FSM=IDLE.
- Input path:
  - 2-flop synchronizer sync1 -> sync2, then a delay flop sync2_d.
  - rise = sync2 & ~sync2_d.
- Latency: if sig_in is high at clk_input edge k (setup met), rise is true in the cycle after edge k+1. Resulting outputs register at edge k+2.
- FSM states:
  - IDLE: counter held at 0. On rise -> MEASURE, counter<=0. No output change.
  - MEASURE: counter increments by 1 each cycle.
    - On rise: period_out<=counter+1, period_vld<=1 for one cycle, locked<=1, timeout<=0, counter<=0. Stay in MEASURE.
    - Else if counter==TIMEOUT-1: -> IDLE, timeout<=1, locked<=0, counter<=0. period_out keeps its last value; no period_vld.
- Period definition: cycles between consecutive detected rising edges. Spacing P gives period_out=P. Max reportable P = TIMEOUT.
- Simultaneous rise and counter==TIMEOUT-1: rise wins. Period TIMEOUT is reported; no timeout.
- The first rise after reset or after a timeout only arms measurement. It never produces period_vld.
- Falling edges are ignored, except by the optional feature.
- Counter never wraps, since TIMEOUT < 2^CNT_W.
- Reset mid-measurement: all state returns to reset values on that edge. A rise pending in the synchronizer is discarded only if sync flops are cleared, which they are.
- sig_in glitches shorter than one clk_input period may be missed. No filtering is required.

Optional Feature:
Macro HIGH_TIME_EN.
- Defined:
  - Adds output high_out [CNT_W-1:0] (reset 0) and a second counter.
  - In MEASURE, the second counter increments on cycles where sync2=1. It is cleared with the main counter on rise.
  - On rise: high_out<=high count, captured before clear and including the current cycle if sync2=1. high_out updates in the same cycle as period_out.
  - Timeout leaves high_out unchanged.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset 3 cycles with sig_in toggling -> all outputs 0. No period_vld within 2 cycles after release.
- Steady period: TIMEOUT=100, sig_in square wave, period 20 cycles (10 high / 10 low).
  - First rise: no pulse. Second rise: period_vld one cycle, 2 edges after the sampling edge, with period_out=20 and locked=1.
  - Every later period: period_out=20.
  - HIGH_TIME_EN: high_out=10.
- Period change: switch to period 37 -> next report 37. Then 8 -> report 8. locked stays 1 throughout.
- Timeout: TIMEOUT=100, stop toggling after a rise.
  - Timeout=1 and locked=0 exactly 100 cycles after that rise was detected.
  - period_out retains its last value.
  - Restart: the first rise arms only. The second rise reports its period and clears timeout.
- Boundary: rise spacing exactly 100 with TIMEOUT=100 -> period_out=100, no timeout. Spacing 101 -> timeout, no report.
- Reset mid-measure: assert reset 50 cycles into a period -> outputs 0, FSM in IDLE. The next two rises yield one report of the correct period.
- Full-scale: default parameters, sig_in from the 100 MHz-to-1 Hz divider (toggles every 50,000,001 cycles) -> period_out=100,000,002, locked=1, no timeout.
